// File: rtl/ktms_fc_drain_wait_if.sv
// Request, counter-read and response signals of the per-id drain waiter.
// master = requester/counter side, slave = the drain waiter itself.
interface ktms_fc_drain_wait_if #(
    parameter int id_width  = 1,
    parameter int tag_width = 8
);
    logic                 i_v;
    logic                 i_r;
    logic [id_width-1:0]  i_id;
    logic [tag_width-1:0] i_tag;
    logic [id_width-1:0]  o_rd_a;
    logic                 i_rd_z;
    logic                 o_v;
    logic                 o_r;
    logic [id_width-1:0]  o_id;
    logic [tag_width-1:0] o_tag;
    logic                 o_tmo;

    modport master (
        output i_v, i_id, i_tag, i_rd_z, o_r,
        input  i_r, o_rd_a, o_v, o_id, o_tag, o_tmo
    );

    modport slave (
        input  i_v, i_id, i_tag, i_rd_z, o_r,
        output i_r, o_rd_a, o_v, o_id, o_tag, o_tmo
    );
endinterface

// File: rtl/ktms_fc_drain_wait.sv
// Per-id drain waiter: queues {id, tag}, waits for the id's counter to read zero, responds in order.
// Latency: push at N -> o_v at N+3 at best; i_r = ~full (no bypass); response held while o_r=0.
// Optional wait timeout built when KTMS_FC_DRAIN_TIMEOUT_EN is defined (sets o_tmo).
module ktms_fc_drain_wait #(
    parameter int id_width   = 1,
    parameter int tag_width  = 8,
    parameter int depth_log2 = 2,
    parameter int tmo_width  = 16
) (
    input  logic                clk,
    input  logic                reset,
    ktms_fc_drain_wait_if.slave bus
);
    localparam int depth = 1 << depth_log2;

    typedef struct packed {
        logic [id_width-1:0]  id;
        logic [tag_width-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, ADDR, POLL, RSP} state_t;

    state_t                state;
    req_t                  mem [depth];
    req_t                  head;
    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic [depth_log2:0]   count;
    logic [depth_log2:0]   count_nxt;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [id_width-1:0]   rd_a_q;
    logic                  o_v_q;
    logic [id_width-1:0]   o_id_q;
    logic [tag_width-1:0]  o_tag_q;
    logic                  tmo_q;
    logic                  tmo_hit;

    assign full      = (count == (depth_log2 + 1)'(depth));
    assign empty     = (count == '0);
    assign push      = bus.i_v & ~full;
    assign pop       = (state == RSP) & bus.o_r;
    assign count_nxt = count + (depth_log2 + 1)'(push) - (depth_log2 + 1)'(pop);
    assign head      = mem[rd_ptr];

    assign bus.i_r    = ~full;
    assign bus.o_rd_a = empty ? rd_a_q : head.id;
    assign bus.o_v    = o_v_q;
    assign bus.o_id   = o_id_q;
    assign bus.o_tag  = o_tag_q;
    assign bus.o_tmo  = tmo_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{id: bus.i_id, tag: bus.i_tag};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_a_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            // o_rd_a keeps the last head id once the queue drains
            if (!empty) rd_a_q <= head.id;
        end
    end

`ifdef KTMS_FC_DRAIN_TIMEOUT_EN
    logic [tmo_width-1:0] tmo_cnt;
    logic [tmo_width-1:0] tmo_cnt_inc;

    assign tmo_cnt_inc = tmo_cnt + 1'b1;
    assign tmo_hit     = ~bus.i_rd_z & (&tmo_cnt_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ADDR) begin
            tmo_cnt <= '0;
        end else if (state == POLL && !bus.i_rd_z && !(&tmo_cnt)) begin
            tmo_cnt <= tmo_cnt_inc;
        end
    end
`else
    // No timeout hardware; tmo_width only matters when the counter is built.
    assign tmo_hit = (tmo_width < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            o_v_q   <= 1'b0;
            o_id_q  <= '0;
            o_tag_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push || !empty) state <= ADDR;
                end
                // counter read address settles here; i_rd_z is for the old address
                ADDR: begin
                    state <= POLL;
                end
                POLL: begin
                    if (bus.i_rd_z || tmo_hit) begin
                        state   <= RSP;
                        o_v_q   <= 1'b1;
                        o_id_q  <= head.id;
                        o_tag_q <= head.tag;
                        tmo_q   <= ~bus.i_rd_z;
                    end
                end
                RSP: begin
                    if (bus.o_r) begin
                        o_v_q <= 1'b0;
                        state <= (count_nxt != '0) ? ADDR : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ktms_fc_drain_wait.sv
// Directed bench for ktms_fc_drain_wait; timeout step only when KTMS_FC_DRAIN_TIMEOUT_EN is defined.
// Inputs driven and outputs checked 1 time unit after each rising edge.
module tb_ktms_fc_drain_wait;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ktms_fc_drain_wait_if #(.id_width(1), .tag_width(8)) bus ();

    ktms_fc_drain_wait #(
        .id_width(1), .tag_width(8), .depth_log2(2), .tmo_width(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic id, input logic [7:0] tag);
        bus.i_v   = v;
        bus.i_id  = id;
        bus.i_tag = tag;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 8'h00);
        bus.i_rd_z = 1'b0;
        bus.o_r    = 1'b1;
        #1;
        // reset state
        chk("rst_i_r",    32'(bus.i_r),    32'd1);
        chk("rst_o_v",    32'(bus.o_v),    32'd0);
        chk("rst_o_id",   32'(bus.o_id),   32'd0);
        chk("rst_o_tag",  32'(bus.o_tag),  32'd0);
        chk("rst_o_tmo",  32'(bus.o_tmo),  32'd0);
        chk("rst_o_rd_a", 32'(bus.o_rd_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // counter already zero: push at c0, o_v at c3
        drive(1'b1, 1'b1, 8'h5A);
        bus.i_rd_z = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'h00);
        chk("t1_c1_rd_a", 32'(bus.o_rd_a), 32'd1);
        chk("t1_c1_o_v",  32'(bus.o_v),    32'd0);
        tick();
        chk("t1_c2_o_v",  32'(bus.o_v),    32'd0);
        tick();
        chk("t1_c3_o_v",  32'(bus.o_v),    32'd1);
        chk("t1_c3_o_id", 32'(bus.o_id),   32'd1);
        chk("t1_c3_tag",  32'(bus.o_tag),  32'h5A);
        chk("t1_c3_tmo",  32'(bus.o_tmo),  32'd0);
        tick();
        chk("t1_c4_o_v",  32'(bus.o_v),    32'd0);
        chk("t1_rd_hold", 32'(bus.o_rd_a), 32'd1);

        // delayed zero: 10 POLL cycles at zero=0, then respond one cycle after zero=1
        bus.i_rd_z = 1'b0;
        drive(1'b1, 1'b0, 8'h33);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        chk("t2_rd_a", 32'(bus.o_rd_a), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_wait_o_v", 32'(bus.o_v), 32'd0);
        end
        bus.i_rd_z = 1'b1;
        tick();
        chk("t2_o_v",  32'(bus.o_v),   32'd1);
        chk("t2_tag",  32'(bus.o_tag), 32'h33);
        chk("t2_o_id", 32'(bus.o_id),  32'd0);
        tick();
        chk("t2_pop_o_v", 32'(bus.o_v), 32'd0);

        // fill FIFO with tags 1..4 (ids 1,0,1,0) while zero=0, response held off
        bus.i_rd_z = 1'b0;
        bus.o_r    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'(i & 1), 8'(i));
            tick();
        end
        chk("t3_full_i_r", 32'(bus.i_r), 32'd0);
        drive(1'b1, 1'b1, 8'h99);
        bus.i_rd_z = 1'b1;
        tick();
        chk("t3_rsp_o_v", 32'(bus.o_v),   32'd1);
        chk("t3_rsp_tag", 32'(bus.o_tag), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_bp_o_v",  32'(bus.o_v),   32'd1);
            chk("t3_bp_o_id", 32'(bus.o_id),  32'd1);
            chk("t3_bp_tag",  32'(bus.o_tag), 32'd1);
            chk("t3_bp_i_r",  32'(bus.i_r),   32'd0);
        end
        bus.o_r = 1'b1;
        chk("t3_pop_cycle_i_r", 32'(bus.i_r), 32'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        chk("t3_after_pop_o_v", 32'(bus.o_v),    32'd0);
        chk("t3_next_rd_a",     32'(bus.o_rd_a), 32'd0);
        chk("t3_after_pop_i_r", 32'(bus.i_r),    32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            tick();
            chk("t3_order_o_v", 32'(bus.o_v),   32'd1);
            chk("t3_order_tag", 32'(bus.o_tag), 32'(k));
            chk("t3_order_id",  32'(bus.o_id),  32'(k & 1));
            tick();
        end
        chk("t3_drained_o_v", 32'(bus.o_v), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_no_stale_o_v", 32'(bus.o_v), 32'd0);
        end

        // reset with 3 queued and o_v=1
        bus.o_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'hA1 + 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        chk("t4_pre_o_v", 32'(bus.o_v),   32'd1);
        chk("t4_pre_tag", 32'(bus.o_tag), 32'hA1);
        reset = 1'b1;
        #1;
        chk("t4_async_o_v", 32'(bus.o_v),    32'd0);
        chk("t4_async_i_r", 32'(bus.i_r),    32'd1);
        chk("t4_async_rd_a", 32'(bus.o_rd_a), 32'd0);
        tick();
        reset = 1'b0;
        bus.o_r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_no_stale_o_v", 32'(bus.o_v), 32'd0);
        end

`ifdef KTMS_FC_DRAIN_TIMEOUT_EN
        // timeout after 15 POLL cycles with zero=0
        bus.i_rd_z = 1'b0;
        drive(1'b1, 1'b1, 8'h77);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t5_wait_o_v", 32'(bus.o_v), 32'd0);
        end
        tick();
        chk("t5_tmo_o_v", 32'(bus.o_v),   32'd1);
        chk("t5_tmo_flag", 32'(bus.o_tmo), 32'd1);
        chk("t5_tmo_tag", 32'(bus.o_tag), 32'h77);
        tick();
        bus.i_rd_z = 1'b1;
        drive(1'b1, 1'b0, 8'h78);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        tick();
        tick();
        chk("t5_next_o_v", 32'(bus.o_v),   32'd1);
        chk("t5_next_tmo", 32'(bus.o_tmo), 32'd0);
        chk("t5_next_tag", 32'(bus.o_tag), 32'h78);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
